player_debounce: RTL
====================

// Module: player_debounce
//
// PURPOSE
//   Input conditioner that sits directly upstream of the fastest-finger-first judge.
//   Takes raw, asynchronous, bouncing player push-buttons and does three things:
//     - synchronises them to clk;
//     - debounces each channel independently;
//     - drives clean levels on player[] into the judge's player inputs.
//   Also emits a one-cycle press pulse per channel, for round/score logic further downstream.
//
// PARAMETERS
//   N_PLAYERS        4    number of button channels
//   DEBOUNCE_CYCLES  16   consecutive cycles a new synchronised value must persist before it is accepted (>=1)
//   CNT_W            5    debounce counter width; 2**CNT_W must exceed DEBOUNCE_CYCLES-1
//
// PORTS
//   clk          in   1          system clock; all state on rising edge
//   rst          in   1          asynchronous, active-high reset
//   btn_raw      in   N_PLAYERS  raw buttons, asynchronous, 1 = pressed
//   player       out  N_PLAYERS  debounced level per channel, registered (feeds judge player[])
//   press_pulse  out  N_PLAYERS  one-cycle high on debounced 0->1 of that channel, registered
//   any_pressed  out  1          OR of player[]
//
// BEHAVIOUR
//   Reset
//     - rst high forces all state to 0, immediately and regardless of clk:
//       sync flops, counters, player, press_pulse; any_pressed=0.
//     - Reset mid-count discards the partial count.
//     - After release, a button held throughout needs the full latency again to appear.
//   Synchroniser
//     - Per bit: btn_raw -> s1 -> s2, two flops.
//     - s2 is the only value the debouncer sees.
//   Debounce, per channel i, every rising edge:
//     - s2[i] == player[i]: cnt[i] <= 0.
//     - s2[i] != player[i] and cnt[i] == DEBOUNCE_CYCLES-1:
//       player[i] <= s2[i]; cnt[i] <= 0.
//     - Otherwise: cnt[i] <= cnt[i]+1.
//     - Any cycle where s2 returns to player restarts the count.
//       Glitches shorter than DEBOUNCE_CYCLES cycles never reach player.
//   Latency
//     - Raw level held stable from before edge 1 appears on player after rising edge 2+DEBOUNCE_CYCLES.
//     - Same latency for press and release.
//   press_pulse
//     - press_pulse[i] <= (update of player[i] from 0 to 1 this edge).
//     - High exactly the one cycle in which player[i] first reads 1.
//     - 0 on release and in all other cycles.
//   Channel independence and simultaneity
//     - Channels are fully independent; no arbitration here (the judge owns priority).
//     - Several channels maturing on the same edge raise their player and press_pulse bits together.
//   Other rules
//     - Counter never exceeds DEBOUNCE_CYCLES-1, so no wrap-around.
//     - any_pressed is combinational from registered player, so it has no extra latency.
//
// TESTING (bench overrides DEBOUNCE_CYCLES=4; btn_raw changed mid-cycle)
//   1. Reset, then btn_raw=0000 for 10 cycles
//      -> player=0000, press_pulse=0000, any_pressed=0 throughout.
//   2. btn_raw[0]=1 held before edge 1
//      -> player=0001 from edge 6 on; press_pulse=0001 only for cycle after edge 6; any_pressed=1.
//   3. btn_raw[1] pulses high for 3 cycles, then 0
//      -> player[1] stays 0 and press_pulse[1] never asserts.
//      Then hold high for 6 cycles -> player[1] rises 6 edges after the hold begins.
//   4. btn_raw=0101 applied in one step
//      -> player 0000->0101 on the same edge; press_pulse=0101 for one cycle.
//      Then btn_raw=0000 -> player=0000 six edges later, no pulse.
//   5. btn_raw[3]=1 held; rst asserted 3 edges after it, between edges
//      -> all outputs 0 at once; after deassert, player[3] rises only 6 edges later.
//   6. Bounce pattern on btn_raw[2] (1,0,1,1,0,1,1,1,1,1, one value per cycle)
//      -> player[2] rises exactly 6 edges after the last 0; exactly one press_pulse.

Source files
------------

// File: rtl/player_debounce.sv
// Player button conditioner: two-flop synchroniser plus per-channel debounce.
// Drives clean levels to the judge and a one-cycle pulse on each accepted press.
module player_debounce #(
  parameter int N_PLAYERS       = 4,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_PLAYERS-1:0] btn_raw,
  output logic [N_PLAYERS-1:0] player,
  output logic [N_PLAYERS-1:0] press_pulse,
  output logic                 any_pressed
);

  localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [N_PLAYERS-1:0] s1;
  logic [N_PLAYERS-1:0] s2;
  logic [CNT_W-1:0]     cnt [N_PLAYERS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= btn_raw;
      s2 <= s1;
    end
  end

  // A channel flips only after s2 has disagreed with player for DEBOUNCE_CYCLES edges in a row.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      player      <= '0;
      press_pulse <= '0;
      for (int i = 0; i < N_PLAYERS; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N_PLAYERS; i++) begin
        press_pulse[i] <= 1'b0;
        if (s2[i] == player[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_TC) begin
          player[i]      <= s2[i];
          press_pulse[i] <= s2[i];
          cnt[i]         <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  assign any_pressed = |player;

endmodule
